// File: rtl/wb_sdr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_sdr_arbiter
//   Round-robin Wishbone arbiter that shares the single SDRAM-controller
//   Wishbone slave port among NUM_M masters. A grant is held for the whole
//   cyc of the winning master, so bursts are never split. A watchdog counts
//   stb-without-ack cycles and returns err to the master if the controller
//   stalls for TIMEOUT_CYC cycles.
//
// Ports
//   sys_clk            system clock (rising edge)
//   wb_rst_i           synchronous active-high reset
//   m_cyc_i/m_stb_i    per-master cyc / stb                 [NUM_M]
//   m_we_i             per-master write enable              [NUM_M]
//   m_sel_i            per-master byte selects, k at [k*dw/8 +: dw/8]
//   m_adr_i            per-master address,      k at [k*APP_AW +: APP_AW]
//   m_dat_i            per-master write data,   k at [k*dw +: dw]
//   m_cti_i            per-master cycle type,   k at [k*3 +: 3]
//   m_ack_o/m_err_o    per-master ack / watchdog error      [NUM_M]
//   m_dat_o            read data broadcast to every master
//   s_*_o              Wishbone master side towards the SDRAM controller
//   s_ack_i/s_dat_i    ack / read data from the controller
//   gnt_o              one-hot current grant
// ---------------------------------------------------------------------------
module wb_sdr_arbiter #(
    parameter int NUM_M       = 2,
    parameter int dw          = 32,
    parameter int APP_AW      = 26,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       sys_clk,
    input  logic                       wb_rst_i,
    input  logic [NUM_M-1:0]           m_cyc_i,
    input  logic [NUM_M-1:0]           m_stb_i,
    input  logic [NUM_M-1:0]           m_we_i,
    input  logic [NUM_M*(dw/8)-1:0]    m_sel_i,
    input  logic [NUM_M*APP_AW-1:0]    m_adr_i,
    input  logic [NUM_M*dw-1:0]        m_dat_i,
    input  logic [NUM_M*3-1:0]         m_cti_i,
    output logic [NUM_M-1:0]           m_ack_o,
    output logic [NUM_M-1:0]           m_err_o,
    output logic [dw-1:0]              m_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [dw/8-1:0]            s_sel_o,
    output logic [APP_AW-1:0]          s_adr_o,
    output logic [dw-1:0]              s_dat_o,
    output logic [2:0]                 s_cti_o,
    input  logic                       s_ack_i,
    input  logic [dw-1:0]              s_dat_i,
    output logic [NUM_M-1:0]           gnt_o
);

    localparam int SW = dw / 8;
    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]     gidx_q, gidx_d;     // binary index of gnt_q
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]     wdog_q, wdog_d;

    logic              found;
    logic [PW-1:0]     pick;
    logic              cyc_g, stb_g;

    assign gnt_o   = gnt_q;
    assign m_dat_o = s_dat_i;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_M; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && m_cyc_i[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Slave-side mux driven by the registered one-hot grant; all zero when
    // nobody holds the grant.
    always_comb begin
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_cti_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gnt_q[k]) begin
                cyc_g   = m_cyc_i[k];
                stb_g   = m_stb_i[k];
                s_we_o  = m_we_i[k];
                s_sel_o = m_sel_i[k*SW +: SW];
                s_adr_o = m_adr_i[k*APP_AW +: APP_AW];
                s_dat_o = m_dat_i[k*dw +: dw];
                s_cti_o = m_cti_i[k*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m_ack_o  = '0;
        m_err_o  = '0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gidx_d      = pick;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o = cyc_g;
                s_stb_o = cyc_g & stb_g;
                m_ack_o = gnt_q & {NUM_M{s_ack_i}};
                if (!cyc_g) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (gidx_q == PW'(NUM_M - 1)) ? '0 : gidx_q + PW'(1);
                    wdog_d   = '0;
                end else if (s_stb_o && !s_ack_i) begin
                    // Stalled beat; an ack in the same cycle takes the
                    // other branch, so ack always beats the timeout.
                    if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                        m_err_o = gnt_q;
                        state_d = ERR;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WW'(1);
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            ERR: begin
                // Controller side stays idle until the master gives up cyc.
                if (!cyc_g) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (gidx_q == PW'(NUM_M - 1)) ? '0 : gidx_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_sdr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_sdr_arbiter
//   Directed bench for wb_sdr_arbiter with two masters and a 16-cycle
//   watchdog. Inputs change 1 time unit after the rising edge and outputs
//   are checked after they settle, away from the edge.
// ---------------------------------------------------------------------------
module tb_wb_sdr_arbiter;

    localparam int NUM_M = 2;
    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int TO    = 16;

    logic                 sys_clk = 1'b0;
    logic                 wb_rst_i = 1'b1;
    logic [NUM_M-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NUM_M*4-1:0]   m_sel = '0;
    logic [NUM_M*AW-1:0]  m_adr = '0;
    logic [NUM_M*DW-1:0]  m_dat = '0;
    logic [NUM_M*3-1:0]   m_cti = '0;
    logic                 s_ack = 1'b0;
    logic [DW-1:0]        s_dat = '0;

    logic [NUM_M-1:0]     m_ack_o, m_err_o, gnt_o;
    logic [DW-1:0]        m_dat_o;
    logic                 s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]           s_sel_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [2:0]           s_cti_o;

    int checks = 0;
    int errors = 0;

    wb_sdr_arbiter #(.NUM_M(NUM_M), .dw(DW), .APP_AW(AW), .TIMEOUT_CYC(TO)) dut (
        .sys_clk (sys_clk),
        .wb_rst_i(wb_rst_i),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_sel_i (m_sel),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_cti_i (m_cti),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_cti_o (s_cti_o),
        .s_ack_i (s_ack),
        .s_dat_i (s_dat),
        .gnt_o   (gnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [2:0] cti);
        m_cyc[k]           = cyc;
        m_stb[k]           = cyc;
        m_we[k]            = we;
        m_sel[k*4 +: 4]    = 4'hF;
        m_adr[k*AW +: AW]  = adr;
        m_dat[k*DW +: DW]  = dat;
        m_cti[k*3 +: 3]    = cti;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        s_ack = 1'b1;
        m_cyc = 2'b11;
        do_reset();
        wb_rst_i = 1'b1;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
        checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got ack=%b err=%b expected 00 00", m_ack_o, m_err_o); end
        s_ack = 1'b0;
        m_cyc = 2'b00;
        wb_rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        s_dat = 32'hCAFE0001;
        set_m(0, 1'b1, 1'b1, 26'h100, 32'hDEADBEEF, 3'b000);
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_latency: got s_cyc_o=%b expected 0 before edge", s_cyc_o); end
        tick();
        checks++; if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin errors++; $display("FAIL single_grant: got gnt=%b cyc=%b stb=%b expected 01 1 1", gnt_o, s_cyc_o, s_stb_o); end
        checks++; if (s_adr_o !== 26'h100 || s_dat_o !== 32'hDEADBEEF || s_we_o !== 1'b1 || s_sel_o !== 4'hF || s_cti_o !== 3'b000) begin errors++; $display("FAIL single_mux: got adr=%h dat=%h we=%b sel=%h cti=%b expected 100 deadbeef 1 f 000", s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cti_o); end
        checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL single_noack: got %b expected 00", m_ack_o); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b01 || m_dat_o !== 32'hCAFE0001) begin errors++; $display("FAIL single_ack: got ack=%b dat=%h expected 01 cafe0001", m_ack_o, m_dat_o); end
        tick();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_drop: got s_cyc_o=%b expected 0", s_cyc_o); end
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", gnt_o); end
    endtask

    task automatic test_contention();
        do_reset();
        set_m(0, 1'b1, 1'b0, 26'h200, '0, 3'b000);
        set_m(1, 1'b1, 1'b0, 26'h300, '0, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 26'h200) begin errors++; $display("FAIL cont_first: got gnt=%b adr=%h expected 01 200", gnt_o, s_adr_o); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL cont_ack0: got %b expected 01", m_ack_o); end
        tick();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL cont_idle_gap: got gnt=%b cyc=%b expected 00 0", gnt_o, s_cyc_o); end
        tick();
        checks++; if (gnt_o !== 2'b10 || s_adr_o !== 26'h300 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL cont_second: got gnt=%b adr=%h cyc=%b expected 10 300 1", gnt_o, s_adr_o, s_cyc_o); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b10) begin errors++; $display("FAIL cont_ack1: got %b expected 10", m_ack_o); end
        tick();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        tick();
    endtask

    task automatic test_burst();
        int good;
        good = 0;
        set_m(0, 1'b1, 1'b0, 26'h400, '0, 3'b010);
        set_m(1, 1'b1, 1'b1, 26'h500, 32'h11112222, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b01 || s_cti_o !== 3'b010) begin errors++; $display("FAIL burst_grant: got gnt=%b cti=%b expected 01 010", gnt_o, s_cti_o); end
        for (int b = 0; b < 8; b++) begin
            s_ack = 1'b1;
            #1;
            if (m_ack_o === 2'b01 && gnt_o === 2'b01 && s_cyc_o === 1'b1) good++;
            tick();
        end
        checks++; if (good !== 8) begin errors++; $display("FAIL burst_acks: got %0d clean beats expected 8", good); end
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL burst_gap: got %b expected 00", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_dat_o !== 32'h11112222) begin errors++; $display("FAIL burst_m1: got gnt=%b we=%b dat=%h expected 10 1 11112222", gnt_o, s_we_o, s_dat_o); end
        set_m(1, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        set_m(0, 1'b1, 1'b0, 26'h600, '0, 3'b000);
        set_m(1, 1'b1, 1'b0, 26'h700, '0, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL burst_rr_wrap: got %b expected 01", gnt_o); end
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        set_m(0, 1'b1, 1'b0, 26'h800, '0, 3'b000);
        tick();
        for (int c = 1; c < TO; c++) begin
            if (m_err_o !== 2'b00 || s_cyc_o !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early: got %0d early err/cyc-loss cycles expected 0", bad); end
        checks++; if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) begin errors++; $display("FAIL to_err: got err=%b ack=%b expected 01 00", m_err_o, m_ack_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b0 || m_err_o !== 2'b00 || gnt_o !== 2'b01) begin errors++; $display("FAIL to_errstate: got cyc=%b err=%b gnt=%b expected 0 00 01", s_cyc_o, m_err_o, gnt_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL to_hold: got s_cyc_o=%b expected 0", s_cyc_o); end
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL to_release: got %b expected 00", gnt_o); end
    endtask

    task automatic test_ack_on_timeout();
        set_m(0, 1'b1, 1'b0, 26'h900, '0, 3'b000);
        tick();
        for (int c = 1; c < TO; c++) tick();
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin errors++; $display("FAIL ackto_same: got ack=%b err=%b expected 01 00", m_ack_o, m_err_o); end
        tick();
        s_ack = 1'b0;
        #1;
        checks++; if (s_cyc_o !== 1'b1 || m_err_o !== 2'b00) begin errors++; $display("FAIL ackto_after: got cyc=%b err=%b expected 1 00", s_cyc_o, m_err_o); end
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        tick();
    endtask

    task automatic test_drop_pending();
        set_m(0, 1'b1, 1'b0, 26'hA00, '0, 3'b000);
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL drop_late_ack: got ack=%b cyc=%b gnt=%b expected 00 0 00", m_ack_o, s_cyc_o, gnt_o); end
        s_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_m(1, 1'b1, 1'b0, 26'hB00, '0, 3'b010);
        tick();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rst_pre_grant: got %b expected 10", gnt_o); end
        s_ack = 1'b1;
        tick();
        tick();
        set_m(0, 1'b1, 1'b0, 26'hC00, '0, 3'b000);
        wb_rst_i = 1'b1;
        tick();
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00 || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL rst_mid: got cyc=%b stb=%b gnt=%b ack=%b err=%b expected all 0", s_cyc_o, s_stb_o, gnt_o, m_ack_o, m_err_o); end
        s_ack = 1'b0;
        tick();
        wb_rst_i = 1'b0;
        tick();
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 26'hC00) begin errors++; $display("FAIL rst_regrant: got gnt=%b adr=%h expected 01 c00", gnt_o, s_adr_o); end
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_burst();
        test_timeout();
        test_ack_on_timeout();
        test_drop_pending();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
